// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for a single-issue RV32I subset (add, sub, addi, bne).
// Fetches over a req/valid handshake, drives the datapath controls and owns pc, retire count and trap.
module datapath_sequencer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     imem_req,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic                     imem_valid,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     eq,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic                     ALUctrl,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     retired,
  output logic [31:0]              instr_count,
  output logic                     halt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_TRAP    = 3'd4
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [31:0]             count_q, count_d;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic                    is_rtype, is_addi, is_bne, supported;
  logic signed [DATA_WIDTH-1:0] imm_i, imm_b, imm_sel;

  function automatic logic signed [DATA_WIDTH-1:0] sext_i(input logic [DATA_WIDTH-1:0] ins);
    return {{(DATA_WIDTH-12){ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sext_b(input logic [DATA_WIDTH-1:0] ins);
    return {{(DATA_WIDTH-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  // Decode is purely combinational from the latched instruction word.
  always_comb begin
    opcode    = instr_q[6:0];
    funct3    = instr_q[14:12];
    funct7    = instr_q[31:25];
    is_rtype  = (opcode == OP_RTYPE) && (funct3 == 3'b000) &&
                ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    is_addi   = (opcode == OP_IMM) && (funct3 == 3'b000);
    is_bne    = (opcode == OP_BRANCH) && (funct3 == 3'b001);
    supported = is_rtype || is_addi || is_bne;
    imm_i     = sext_i(instr_q);
    imm_b     = sext_b(instr_q);
    imm_sel   = is_bne ? imm_b : imm_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = supported ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        // Only a not-taken-equal bne redirects; everything else falls through.
        if (is_bne && !eq) pc_d = pc_q + $unsigned(imm_b);
        else               pc_d = pc_q + DATA_WIDTH'(4);
        count_d = count_q + 32'd1;
        state_d = en ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH);
    imem_addr   = pc_q;
    retired     = (state_q == S_EXECUTE);
    RegWrite    = (state_q == S_EXECUTE) && (is_rtype || is_addi) &&
                  (instr_q[11:7] != 5'd0);
    halt        = (state_q == S_TRAP);
    ALUsrc      = is_addi;
    ALUctrl     = is_bne || (is_rtype && funct7[5]);
    ImmOp       = $unsigned(imm_sel);
    rs1         = ADDRESS_WIDTH'(instr_q[19:15]);
    rs2         = ADDRESS_WIDTH'(instr_q[24:20]);
    rd          = ADDRESS_WIDTH'(instr_q[11:7]);
    pc          = pc_q;
    instr_count = count_q;
  end

endmodule
